// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - encodings shared by the CPU sequencer and its neighbours
package cpu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_WAIT   = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_GETA   = 3'd2;
  localparam state_t S_GETB   = 3'd3;
  localparam state_t S_EXEC   = 3'd4;
  localparam state_t S_WRREG  = 3'd5;
  localparam state_t S_WRIMM  = 3'd6;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

  localparam logic [3:0] VSEL_C     = 4'b0001;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_IMM8  = 4'b0100;
  localparam logic [3:0] VSEL_MDATA = 4'b1000;

endpackage

// File: rtl/cpu_seq_fsm.sv
// rtl/cpu_seq_fsm.sv - Moore sequencer driving the register file, A/B/C, ALU and status
module cpu_seq_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic [3:0] vsel
);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] instr_q;

  logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn;

  assign is_mov_imm = (instr_q == {OPC_MOV, OP_MOV_IMM});
  assign is_mov_reg = (instr_q == {OPC_MOV, OP_MOV_REG});
  assign is_add     = (instr_q == {OPC_ALU, OP_ADD});
  assign is_cmp     = (instr_q == {OPC_ALU, OP_CMP});
  assign is_and     = (instr_q == {OPC_ALU, OP_AND});
  assign is_mvn     = (instr_q == {OPC_ALU, OP_MVN});

  // The instruction is captured only on the start edge so decoder changes mid-run are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_WAIT;
      instr_q <= 5'b00000;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && s) begin
        instr_q <= {opcode, op};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: begin
        if (s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                  state_nxt = S_WRIMM;
        else if (is_mov_reg || is_mvn)   state_nxt = S_GETB;
        else if (is_add || is_cmp || is_and) state_nxt = S_GETA;
        else                             state_nxt = S_WAIT;
      end
      S_GETA:  state_nxt = S_GETB;
      S_GETB:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_cmp ? S_WAIT : S_WRREG;
      S_WRREG: state_nxt = S_WAIT;
      S_WRIMM: state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w     = 1'b0;
    nsel  = NSEL_NONE;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    write = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = VSEL_C;
    case (state)
      S_WAIT: w = 1'b1;
      S_GETA: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GETB: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_EXEC: begin
        // Single-operand ops feed 0 on A so the ALU passes the shifted B through.
        asel  = is_mov_reg || is_mvn;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WRREG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_WRIMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_seq_fsm.sv
// tb/tb_cpu_seq_fsm.sv - directed bench for the CPU sequencer
module tb_cpu_seq_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads, write, asel, bsel;
  logic [3:0] vsel;

  int checks = 0;
  int failures = 0;

  cpu_seq_fsm dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .write(write), .asel(asel), .bsel(bsel), .vsel(vsel)
  );

  always #5 clk = ~clk;

  // {w, nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel}
  function automatic logic [14:0] mk(input logic w_, input logic [2:0] ns,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic wr, input logic as_,
                                     input logic bs, input logic [3:0] vs);
    return {w_, ns, la, lb, lc, ls, wr, as_, bs, vs};
  endfunction

  logic [14:0] x_wait, x_dec, x_geta, x_getb, x_exec_alu, x_exec_one, x_exec_cmp, x_wrreg, x_wrimm;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [14:0] e);
    logic [14:0] o;
    o = {w, nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic start(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op     = o;
    s      = 1'b1;
    step();
    s      = 1'b0;
  endtask

  initial begin
    x_wait     = mk(1'b1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
    x_dec      = mk(1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
    x_geta     = mk(1'b0, 3'b100, 1, 0, 0, 0, 0, 0, 0, 4'b0001);
    x_getb     = mk(1'b0, 3'b001, 0, 1, 0, 0, 0, 0, 0, 4'b0001);
    x_exec_alu = mk(1'b0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 4'b0001);
    x_exec_one = mk(1'b0, 3'b000, 0, 0, 1, 0, 0, 1, 0, 4'b0001);
    x_exec_cmp = mk(1'b0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 4'b0001);
    x_wrreg    = mk(1'b0, 3'b010, 0, 0, 0, 0, 1, 0, 0, 4'b0001);
    x_wrimm    = mk(1'b0, 3'b100, 0, 0, 0, 0, 1, 0, 0, 4'b0100);

    reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
    step();
    step();
    check("reset_held", x_wait);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_wait", x_wait);
    end

    // MOV Rn,#im8
    start(3'b110, 2'b10);
    check("movi_decode", x_dec);
    step(); check("movi_wrimm", x_wrimm);
    step(); check("movi_done", x_wait);

    // ADD
    start(3'b101, 2'b00);
    check("add_decode", x_dec);
    step(); check("add_geta", x_geta);
    step(); check("add_getb", x_getb);
    step(); check("add_exec", x_exec_alu);
    step(); check("add_wrreg", x_wrreg);
    step(); check("add_done", x_wait);

    // CMP
    start(3'b101, 2'b01);
    check("cmp_decode", x_dec);
    step(); check("cmp_geta", x_geta);
    step(); check("cmp_getb", x_getb);
    step(); check("cmp_exec", x_exec_cmp);
    step(); check("cmp_done", x_wait);

    // MVN
    start(3'b101, 2'b11);
    check("mvn_decode", x_dec);
    step(); check("mvn_getb", x_getb);
    step(); check("mvn_exec", x_exec_one);
    step(); check("mvn_wrreg", x_wrreg);
    step(); check("mvn_done", x_wait);

    // MOV Rd,Rm,sh
    start(3'b110, 2'b00);
    check("movr_decode", x_dec);
    step(); check("movr_getb", x_getb);
    step(); check("movr_exec", x_exec_one);
    step(); check("movr_wrreg", x_wrreg);
    step(); check("movr_done", x_wait);

    // AND, opcode changed to 111 during GETB must not disturb it
    start(3'b101, 2'b10);
    check("and_decode", x_dec);
    step(); check("and_geta", x_geta);
    step(); check("and_getb", x_getb);
    opcode = 3'b111; op = 2'b11;
    step(); check("and_exec", x_exec_alu);
    step(); check("and_wrreg", x_wrreg);
    step(); check("and_done", x_wait);

    // Illegal opcodes
    start(3'b000, 2'b00);
    check("ill0_decode", x_dec);
    step(); check("ill0_done", x_wait);
    start(3'b110, 2'b01);
    check("ill1_decode", x_dec);
    step(); check("ill1_done", x_wait);

    // Reset during EXEC of ADD
    start(3'b101, 2'b00);
    step(); check("rst_geta", x_geta);
    step(); check("rst_getb", x_getb);
    step(); check("rst_exec", x_exec_alu);
    reset = 1'b1;
    step(); check("rst_abort", x_wait);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_after", x_wait);
    end

    // Back-to-back MOV imm with s held high
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    step(); check("b2b_dec1", x_dec);
    step(); check("b2b_wrimm1", x_wrimm);
    step(); check("b2b_wait", x_wait);
    step(); check("b2b_dec2", x_dec);
    step(); check("b2b_wrimm2", x_wrimm);
    s = 1'b0;
    step(); check("b2b_done", x_wait);
    step(); check("b2b_idle", x_wait);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_seq_fsm.md
Name: cpu_seq_fsm

Overview:
- Moore controller that sequences the Lab-6 CPU datapath: register file, A/B/C pipeline registers, shifter, ALU and status register.
- Consumes opcode/op from the instruction decoder and produces nsel, the load enables, the mux selects, the register-file write strobe, and the wait flag w.
- Sits beside the instruction decoder inside the CPU top. The instruction register is loaded externally before s is asserted.

Parameters:
- None. Encodings are fixed constants in cpu_pkg.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- s  in  1  start; level-sensitive, sampled only in WAIT.
- opcode  in  3  instruction bits [15:13] from the decoder.
- op  in  2  instruction bits [12:11] from the decoder.
- w  out  1  1 only in WAIT (ready for next instruction).
- nsel  out  3  register select, one-hot: 001=Rm, 010=Rd, 100=Rn, 000=none.
- loada  out  1  load register A.
- loadb  out  1  load register B.
- loadc  out  1  load register C.
- loads  out  1  load status flags (Z,N,V).
- write  out  1  register-file write strobe.
- asel  out  1  1 forces ALU A input to 0.
- bsel  out  1  1 selects sximm5 for ALU B input.
- vsel  out  4  write-back select, one-hot: 0001=C, 0010=PC, 0100=sximm8, 1000=mdata.

Behaviour:
- States: WAIT, DECODE, GETA, GETB, EXEC, WRREG, WRIMM.
- Outputs are a pure function of state plus the latched {opcode,op} (Moore). Every output not listed for a state is 0; nsel=000, vsel=0001 as default.
- Reset (synchronous): state goes to WAIT and the latched {opcode,op} clears to 00000. Reset outputs are w=1 and all strobes 0.
- Reset mid-instruction: abort at the next edge; no write or loads occurs in any later cycle.
- WAIT: w=1. If s=1 at the edge, latch {opcode,op} and go to DECODE; else stay in WAIT. After latching, later changes on opcode/op are ignored until the next WAIT.
- DECODE: no strobes. Next state by the latched {opcode,op}:
  - 110_10 (MOV Rn,#im8) -> WRIMM.
  - 110_00 (MOV Rd,Rm,sh) -> GETB.
  - 101_00 (ADD), 101_01 (CMP), 101_10 (AND) -> GETA.
  - 101_11 (MVN) -> GETB.
  - Any other code -> WAIT, with no register or status side effects.
- GETA: nsel=100, loada=1 -> GETB.
- GETB: nsel=001, loadb=1 -> EXEC.
- EXEC: bsel=0.
  - asel=1 for MOV-reg/MVN; asel=0 for ADD/CMP/AND.
  - CMP: loads=1, loadc=0 -> WAIT.
  - Others: loadc=1 -> WRREG.
- WRREG: nsel=010, vsel=0001, write=1 -> WAIT.
- WRIMM: nsel=100, vsel=0100, write=1 -> WAIT.
- Cycle counts (s-sampling edge to w=1 again):
  - MOV imm: 3.
  - MOV reg, MVN: 5.
  - ADD, AND: 6.
  - CMP: 5.
  - Illegal: 2.
- s held high continuously: a new instruction starts at the first edge in WAIT, giving back-to-back execution. w is high for exactly that one WAIT cycle.
- write is asserted for exactly one cycle per writing instruction and never alongside loada, loadb or loadc.

Decomposition:
- cpu_pkg holds:
  - state enum (3-bit);
  - opcode/op constants: OPC_MOV=110, OPC_ALU=101, OP_ADD=00, OP_CMP=01, OP_AND=10, OP_MVN=11;
  - NSEL_RM/RD/RN;
  - VSEL_C/PC/IMM8/MDATA.
- Single module: state register, instruction latch, next-state logic and output decode. No sub-module is warranted.

Test Plan:
- Reset held 2 cycles, then released with s=0 -> w=1, all strobes 0, state WAIT for 5 cycles.
- opcode=110, op=10, s pulsed 1 cycle -> DECODE, then WRIMM with nsel=100, vsel=0100, write=1 for exactly 1 cycle; w=1 on cycle 3.
- ADD (101_00) -> sequence loada(nsel=100), loadb(nsel=001), loadc with asel=0, then write with nsel=010 and vsel=0001; w returns at cycle 6.
- CMP (101_01) -> loads=1 in EXEC, loadc=0, write never asserted; w returns at cycle 5. MVN (101_11) -> no loada, asel=1 in EXEC, write in WRREG.
- Change opcode to 111 during GETB of an ADD -> ADD completes unchanged. Illegal opcode 000 -> DECODE then WAIT, no strobes.
- Assert reset during EXEC of an ADD -> WAIT next cycle, write=0 throughout. s held high across two MOV-imm instructions -> back-to-back execution, with w high 1 cycle between them.
